sram_controller: RTL
====================

Name: sram_controller

Overview:
- Downstream of the MEM stage; converts one 32-bit word load/store into two sequential 16-bit accesses on the off-chip SRAM.
- Holds `ready` low while an access is in flight. The pipeline uses `~ready` to freeze the IF/ID/EXE/MEM pipeline registers.
- Fixed, deterministic latency per access; no caching, no buffering beyond a single request.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- WAIT_CYCLES, 3: idle padding states after the second halfword, before completion (0..15).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset; synchronous, active-high
- wr_en  input  1  store request (MEM_W from EXE/MEM register)
- rd_en  input  1  load request (MEM_R from EXE/MEM register)
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (val_rm)
- read_data  output  32  load result, valid while ready=1 after a read
- ready  output  1  1 = no access pending / access completing this cycle
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_adr  output  18  SRAM halfword address
- SRAM_UB_N  output  1  tied 0
- SRAM_LB_N  output  1  tied 0
- SRAM_WE_N  output  1  write strobe, active low
- SRAM_CE_N  output  1  tied 0
- SRAM_OE_N  output  1  tied 0

Behaviour:
- States: IDLE, LO, HI, WAIT, DONE. State, counter, latched operands and read_data are all registers; SRAM pins are combinational from state plus latched operands.
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, wait counter=0, read_data=0, latched addr/data/op=0.
  - After the edge: SRAM_WE_N=1, SRAM_DQ=Z, ready=1 (if no request).
  - A reset mid-access aborts immediately. No completion is issued, and partial write halves already written stay in SRAM.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational, so the freeze starts in the same cycle the request appears.
  - On a request, latch the operands: op = write if wr_en, else read. wr_en wins if both are set. Then go to LO.
  - Latched halfword base: hw = {(address - BASE_ADDR)[18:2], 1'b0}, computed on 32 bits and truncated.
- LO: SRAM_adr = hw.
  - Write: SRAM_WE_N=0, SRAM_DQ = wdata[15:0].
  - Read: SRAM_WE_N=1, DQ=Z; read_data[15:0] <= SRAM_DQ at the end of the cycle.
  - Go to HI.
- HI: SRAM_adr = hw+1.
  - Write: WE_N=0, DQ = wdata[31:16].
  - Read: read_data[31:16] <= SRAM_DQ.
  - Go to WAIT (counter loaded with WAIT_CYCLES-1), or to DONE if WAIT_CYCLES=0.
- WAIT: WE_N=1, DQ=Z, SRAM_adr held at hw+1. Decrement the counter; go to DONE when it is 0.
- DONE: ready=1 for exactly one cycle; read_data is stable. Go to IDLE unconditionally. A request present during DONE is the same, still-frozen request and is not re-launched.
- ready=0 in LO, HI and WAIT regardless of inputs.
- Latency: the request is first seen in IDLE at cycle 0; ready=1 at cycle 3+WAIT_CYCLES (cycle 6 with defaults). Back-to-back requests restart from IDLE the cycle after DONE.
- read_data keeps its last value across writes and idle cycles.
- wr_en/rd_en/address changes after the latch are ignored until IDLE.
- SRAM_DQ is driven only in LO/HI of a write; it is Z at all other times, including reset.

Optional Feature:
- Macro: SRAM_RANGE_CHECK_EN.
- Defined: a request with address < BASE_ADDR, or (address - BASE_ADDR) ≥ 2^19, goes IDLE→DONE directly.
  - No SRAM cycle is issued: WE_N stays 1 and DQ stays Z.
  - Reads load read_data=0.
  - ready=1 at cycle 1.
- Not defined: no check; the address is truncated to 18 bits as above and always takes the full latency.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-write (in HI) → next cycle state IDLE, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0, ready=1.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF →
  - cycle1: SRAM_adr=0, DQ=0xBEEF, WE_N=0.
  - cycle2: SRAM_adr=1, DQ=0xDEAD, WE_N=0.
  - cycles 0–5: ready=0; cycle 6: ready=1.
- Read: SRAM model holds hw 4=0x5678, hw 5=0x1234; rd_en=1, address=1032 → read_data=0x12345678 with ready=1 at cycle 6; read_data unchanged afterwards.
- Simultaneous: wr_en=rd_en=1, address=1028, data=0x0000A5A5 → write performed (hw 2=0xA5A5, hw 3=0x0000); read_data unchanged.
- Back-to-back: write 0x11223344 @1040, then read @1040 immediately → second access starts the cycle after DONE; read_data=0x11223344 at cycle 13.
- SRAM_RANGE_CHECK_EN defined: rd_en=1, address=16 → no WE_N/DQ activity, ready=1 at cycle 1, read_data=0.

Source files
------------

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle for sram_controller.
// master = MEM stage issuing loads/stores, slave = the controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: one 32-bit word load/store as two sequential 16-bit SRAM accesses.
// Optional macro SRAM_RANGE_CHECK_EN completes out-of-window requests without an SRAM cycle.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_adr,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N,
    output logic             SRAM_WE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_OE_N
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic [17:0] hw_q;
    logic [31:0] wdata_q;
    logic        op_wr_q;
    logic [31:0] read_data_q;

    logic        req;
    logic        range_err;
    logic [16:0] word_idx;
    logic        dq_drive;
    logic [15:0] dq_out;
    logic        ready_c;

    assign req      = bus.wr_en | bus.rd_en;
    assign word_idx = 17'((bus.address - BASE_ADDR) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
    assign range_err = (bus.address < BASE_ADDR) ||
                       ((bus.address - BASE_ADDR) >= 32'h0008_0000);
`else
    assign range_err = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        dq_drive = 1'b0;
        dq_out   = wdata_q[15:0];
        SRAM_adr = hw_q;
        ready_c  = 1'b0;
        case (state)
            // Combinational so the pipeline freezes in the same cycle the request appears.
            S_IDLE: ready_c = ~req;
            S_LO:   dq_drive = op_wr_q;
            S_HI: begin
                SRAM_adr = hw_q + 18'd1;
                dq_out   = wdata_q[31:16];
                dq_drive = op_wr_q;
            end
            S_WAIT: SRAM_adr = hw_q + 18'd1;
            S_DONE: ready_c = 1'b1;
            default: ;
        endcase
    end

    assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
    assign SRAM_WE_N = ~dq_drive;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.ready     = ready_c;
    assign bus.read_data = read_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            hw_q        <= 18'd0;
            wdata_q     <= 32'd0;
            op_wr_q     <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_wr_q <= bus.wr_en;
                        hw_q    <= {word_idx, 1'b0};
                        wdata_q <= bus.write_data;
                        if (range_err) begin
                            if (!bus.wr_en) read_data_q <= 32'd0;
                            state <= S_DONE;
                        end else begin
                            state <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (!op_wr_q) read_data_q[15:0] <= SRAM_DQ;
                    state <= S_HI;
                end
                S_HI: begin
                    if (!op_wr_q) read_data_q[31:16] <= SRAM_DQ;
                    if (WAIT_CYCLES == 0) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_DONE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
